stream_sink_checker: RTL and testbench
======================================

// Module: stream_sink_checker
// PURPOSE
//   Receiving end of the vaild/ready stream: terminates the source -> backward-registered -> forward-registered
//   chain in place of a plain destination. Applies externally driven backpressure and checks every accepted
//   beat against an incrementing reference sequence. Also checks the stall rules of the handshake itself.
//   Reports sticky errors, an error count and a done flag for self-checking benches.
// PARAMETERS
//   WIDTH  9    data width in bits
//   DEPTH  256  number of beats to accept before DONE; 1..2^16
//   START  0    expected value of the first beat; WIDTH bits
// PORTS
//   clk        in   1        single clock, all logic on posedge
//   s_rst      in   1        synchronous reset, active-high
//   vaild      in   1        upstream valid
//   data_in    in   WIDTH    upstream data
//   ready_in   in   1        backpressure enable, e.g. random in a bench; 1 = willing to accept
//   ready      out  1        registered ready to upstream
//   expect     out  WIDTH    next expected data value
//   rx_cnt     out  17       beats accepted so far
//   err_cnt    out  8        sequence mismatches, saturating at 255
//   seq_err    out  1        sticky: at least one data mismatch
//   proto_err  out  1        sticky: upstream broke a stall rule
//   done       out  1        DEPTH beats accepted
// BEHAVIOUR
//   Reset (s_rst=1 at posedge)
//     - State = IDLE. All outputs 0, except expect = START. Internal hold registers cleared.
//     - Reset asserted mid-stream aborts at once. Partial counts and errors are discarded.
//     - There is no drain; the next run starts clean.
//   Transfer: xfer = vaild & ready, sampled at posedge.
//   FSM
//     - IDLE: ready=0. Goes to RUN on the first cycle with s_rst=0, so ready can rise one cycle later.
//     - RUN:  ready <= ready_in every cycle, so ready lags ready_in by exactly 1 clk.
//             On xfer: rx_cnt increments. When rx_cnt reaches DEPTH, the FSM goes to DONE.
//     - DONE: ready <= 0 on the same edge that accepts the last beat. done=1. All counters and flags frozen.
//             DONE is left only through s_rst.
//   Sequence check, on each xfer
//     - Mismatch when data_in != expect. A mismatch sets seq_err and increments err_cnt (saturating at 255).
//     - expect <= data_in + 1, modulo 2^WIDTH. This resyncs after a gap, so one dropped beat counts as one error.
//     - Wrap from all-ones to 0 is legal and is not an error.
//   Stall-rule check
//     - A stall is registered when vaild=1 & ready=0 at a posedge. The registers keep stalled=1 and held=data_in.
//     - On the next posedge, if stalled=1, then vaild=0 or data_in != held sets proto_err.
//     - The check runs in RUN and DONE, but never in IDLE.
//     - The hold is released at the first xfer, or when the stall register clears.
//   Simultaneous events
//     - A mismatch on the final beat is counted before done asserts. Both update on the same edge.
//     - A stall violation and a mismatch in the same cycle set both flags.
//   vaild with ready=0 never changes rx_cnt, expect or err_cnt.
//   No combinational path from any input to any output. All outputs are registered.
// TESTING
//   1. Reset 5 clk, then ready_in=1 and source sends 0..255 back-to-back.
//      -> ready=1 from 2nd clk after reset, done at 256th xfer, rx_cnt=256, err_cnt=0, both flags 0.
//   2. ready_in random for 300 clk, then held at 1, full chain (source/backward/forward) with DEPTH=256.
//      -> done=1, seq_err=0, proto_err=0, ready=0 in DONE.
//   3. Inject stream 0,1,2,4,5,7 with DEPTH=6.
//      -> err_cnt=2, seq_err=1, expect=8 at done.
//   4. Force vaild low for 1 clk while ready=0 during a stall.
//      -> proto_err=1 on the next posedge. In a separate run, change data 3->9 mid-stall -> proto_err=1.
//   5. WIDTH=4, START=14, DEPTH=4, stream 14,15,0,1.
//      -> wrap is accepted, err_cnt=0, done=1, expect=2.
//   6. Assert s_rst for 1 clk after 100 beats.
//      -> next clk: rx_cnt=0, flags 0, expect=START, ready=0. The re-run then passes as in test 1.

Source files
------------

// File: rtl/stream_sink_checker.sv
// stream_sink_checker: receiving end of a valid/ready stream.
// It applies registered backpressure from ready_in and checks each accepted
// beat against an incrementing reference. It also flags an upstream that
// drops valid or changes data while stalled. All outputs come from registers.
`timescale 1ns/1ps

module stream_sink_checker #(
    parameter int               WIDTH = 9,
    parameter int               DEPTH = 256,
    parameter logic [WIDTH-1:0] START = '0
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic             vaild,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ready_in,
    output logic             ready,
    // Named expect_data because `expect` is a reserved SystemVerilog keyword.
    output logic [WIDTH-1:0] expect_data,
    output logic [16:0]      rx_cnt,
    output logic [7:0]       err_cnt,
    output logic             seq_err,
    output logic             proto_err,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [16:0] LAST_IDX = 17'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_ready;
    logic             w_ready_next;
    logic [WIDTH-1:0] r_expect;
    logic [16:0]      r_rx_cnt;
    logic [7:0]       r_err_cnt;
    logic             r_seq_err;
    logic             r_proto_err;
    logic             r_done;
    logic             r_stalled;
    logic [WIDTH-1:0] r_held;

    logic             w_xfer;
    logic             w_last;
    logic             w_mismatch;
    logic             w_stall_viol;

    assign w_xfer       = vaild & r_ready;
    assign w_last       = w_xfer & (r_rx_cnt == LAST_IDX);
    assign w_mismatch   = w_xfer & (data_in != r_expect);
    // A beat seen while stalled must still be offered, unchanged, one edge later.
    assign w_stall_viol = (r_state != ST_IDLE) & r_stalled &
                          (~vaild | (data_in != r_held));

    // State register; the reset is synchronous, so it only acts on a clock edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always written with <= so every register
        // samples pre-edge values, independent of block ordering.
        if (s_rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= w_ready_next;
        end
    end

    // Next state and next ready: ready follows ready_in one clock late while
    // running, and drops on the edge that accepts the final beat.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal
        // unassigned and infers a latch.
        w_state_next = r_state;
        w_ready_next = 1'b0;
        case (r_state)
            ST_IDLE: w_state_next = ST_RUN;
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_ready_next = ready_in;
                end
            end
            ST_DONE: w_state_next = ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Beat counting and sequence check; frozen once DONE because ready stays 0.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_rx_cnt  <= '0;
            r_expect  <= START;
            r_err_cnt <= '0;
            r_seq_err <= 1'b0;
            r_done    <= 1'b0;
        end else if (w_xfer) begin
            r_rx_cnt <= r_rx_cnt + 17'd1;
            // Resync to the received value so a dropped beat costs one error.
            r_expect <= data_in + WIDTH'(1);
            if (w_mismatch) begin
                r_seq_err <= 1'b1;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
            if (w_last) begin
                r_done <= 1'b1;
            end
        end
    end

    // Stall tracking: remember a beat offered against ready=0 and check it next edge.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_stalled   <= 1'b0;
            r_held      <= '0;
            r_proto_err <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_stalled <= 1'b0;
            r_held    <= '0;
        end else begin
            r_stalled <= vaild & ~r_ready;
            r_held    <= data_in;
            if (w_stall_viol) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign ready       = r_ready;
    assign expect_data = r_expect;
    assign rx_cnt      = r_rx_cnt;
    assign err_cnt     = r_err_cnt;
    assign seq_err     = r_seq_err;
    assign proto_err   = r_proto_err;
    assign done        = r_done;

endmodule

// File: tb/tb_stream_sink_checker.sv
// Directed bench for stream_sink_checker. Three instances cover the three
// parameter sets: A (9-bit, 256 beats, start 0), B (9-bit, 6 beats, start 0)
// and C (4-bit, 4 beats, start 14). A behavioural source holds each beat
// until the sink accepts it.
`timescale 1ns/1ps

module tb_stream_sink_checker;

    logic        clk;
    logic        s_rst;
    logic        vaild_v [3];
    logic [8:0]  data_v  [3];
    logic        rin_v   [3];
    logic        rdy_v   [3];
    logic [16:0] rx_v    [3];
    logic [7:0]  err_v   [3];
    logic        seq_v   [3];
    logic        proto_v [3];
    logic        done_v  [3];
    logic [8:0]  exp_a;
    logic [8:0]  exp_b;
    logic [3:0]  exp_c;

    int n_cmp = 0;
    int n_mis = 0;
    int beat_q[$];

    stream_sink_checker #(.WIDTH(9), .DEPTH(256), .START(9'd0)) u_dut_a (
        .clk(clk), .s_rst(s_rst), .vaild(vaild_v[0]), .data_in(data_v[0]),
        .ready_in(rin_v[0]), .ready(rdy_v[0]), .expect_data(exp_a),
        .rx_cnt(rx_v[0]), .err_cnt(err_v[0]), .seq_err(seq_v[0]),
        .proto_err(proto_v[0]), .done(done_v[0])
    );

    stream_sink_checker #(.WIDTH(9), .DEPTH(6), .START(9'd0)) u_dut_b (
        .clk(clk), .s_rst(s_rst), .vaild(vaild_v[1]), .data_in(data_v[1]),
        .ready_in(rin_v[1]), .ready(rdy_v[1]), .expect_data(exp_b),
        .rx_cnt(rx_v[1]), .err_cnt(err_v[1]), .seq_err(seq_v[1]),
        .proto_err(proto_v[1]), .done(done_v[1])
    );

    stream_sink_checker #(.WIDTH(4), .DEPTH(4), .START(4'd14)) u_dut_c (
        .clk(clk), .s_rst(s_rst), .vaild(vaild_v[2]), .data_in(data_v[2][3:0]),
        .ready_in(rin_v[2]), .ready(rdy_v[2]), .expect_data(exp_c),
        .rx_cnt(rx_v[2]), .err_cnt(err_v[2]), .seq_err(seq_v[2]),
        .proto_err(proto_v[2]), .done(done_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        s_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vaild_v[i] = 1'b0;
            data_v[i]  = '0;
            rin_v[i]   = 1'b0;
        end
        repeat (n) cycle();
        s_rst = 1'b0;
    endtask

    // Send every value in beat_q to instance idx, holding each beat until it
    // is accepted. ready_in is random for the first rand_cycles clocks.
    task automatic feed(input int idx, input int budget, input int rand_cycles);
        int sent;
        int cyc;
        int v;
        bit fire;
        sent = 0;
        cyc  = 0;
        while (sent < beat_q.size() && cyc < budget) begin
            v            = beat_q[sent];
            vaild_v[idx] = 1'b1;
            data_v[idx]  = v[8:0];
            rin_v[idx]   = (cyc < rand_cycles) ? ($urandom_range(0, 1) == 1) : 1'b1;
            fire         = rdy_v[idx];
            cycle();
            cyc++;
            if (fire) sent++;
        end
        vaild_v[idx] = 1'b0;
        n_cmp++;
        if (sent != beat_q.size()) begin
            n_mis++;
            $display("FAIL feed_timeout[%0d]: sent %0d, required %0d", idx, sent, beat_q.size());
        end
    endtask

    task automatic test_reset();
        s_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vaild_v[i] = 1'b0;
            data_v[i]  = '0;
            rin_v[i]   = 1'b1;
        end
        repeat (5) cycle();
        n_cmp++; if (rdy_v[0] !== 1'b0)   begin n_mis++; $display("FAIL rst_ready: got %0d want 0", rdy_v[0]); end
        n_cmp++; if (exp_a !== 9'd0)      begin n_mis++; $display("FAIL rst_expect_a: got %0d want 0", exp_a); end
        n_cmp++; if (exp_c !== 4'd14)     begin n_mis++; $display("FAIL rst_expect_c: got %0d want 14", exp_c); end
        n_cmp++; if (rx_v[0] !== 17'd0)   begin n_mis++; $display("FAIL rst_rx_cnt: got %0d want 0", rx_v[0]); end
        n_cmp++; if (err_v[0] !== 8'd0)   begin n_mis++; $display("FAIL rst_err_cnt: got %0d want 0", err_v[0]); end
        n_cmp++; if ({seq_v[0], proto_v[0], done_v[0]} !== 3'b000)
            begin n_mis++; $display("FAIL rst_flags: got %b want 000", {seq_v[0], proto_v[0], done_v[0]}); end
        s_rst = 1'b0;
        cycle();
        n_cmp++; if (rdy_v[0] !== 1'b0) begin n_mis++; $display("FAIL ready_clk1: got %0d want 0", rdy_v[0]); end
        cycle();
        n_cmp++; if (rdy_v[0] !== 1'b1) begin n_mis++; $display("FAIL ready_clk2: got %0d want 1", rdy_v[0]); end
    endtask

    task automatic test_back_to_back();
        beat_q.delete();
        for (int i = 0; i < 255; i++) beat_q.push_back(i);
        feed(0, 400, 0);
        n_cmp++; if (done_v[0] !== 1'b0)  begin n_mis++; $display("FAIL b2b_done_early: got %0d want 0", done_v[0]); end
        n_cmp++; if (rx_v[0] !== 17'd255) begin n_mis++; $display("FAIL b2b_rx_255: got %0d want 255", rx_v[0]); end
        beat_q.delete();
        beat_q.push_back(255);
        feed(0, 10, 0);
        n_cmp++; if (done_v[0] !== 1'b1)  begin n_mis++; $display("FAIL b2b_done: got %0d want 1", done_v[0]); end
        n_cmp++; if (rx_v[0] !== 17'd256) begin n_mis++; $display("FAIL b2b_rx: got %0d want 256", rx_v[0]); end
        n_cmp++; if (err_v[0] !== 8'd0)   begin n_mis++; $display("FAIL b2b_err: got %0d want 0", err_v[0]); end
        n_cmp++; if ({seq_v[0], proto_v[0]} !== 2'b00)
            begin n_mis++; $display("FAIL b2b_flags: got %b want 00", {seq_v[0], proto_v[0]}); end
        n_cmp++; if (rdy_v[0] !== 1'b0)   begin n_mis++; $display("FAIL b2b_ready_done: got %0d want 0", rdy_v[0]); end
        n_cmp++; if (exp_a !== 9'd256)    begin n_mis++; $display("FAIL b2b_expect: got %0d want 256", exp_a); end
        repeat (3) cycle();
        n_cmp++; if (rx_v[0] !== 17'd256) begin n_mis++; $display("FAIL b2b_frozen: got %0d want 256", rx_v[0]); end
    endtask

    task automatic test_random_backpressure();
        do_reset(2);
        beat_q.delete();
        for (int i = 0; i < 256; i++) beat_q.push_back(i);
        feed(0, 3000, 300);
        n_cmp++; if (done_v[0] !== 1'b1)  begin n_mis++; $display("FAIL rnd_done: got %0d want 1", done_v[0]); end
        n_cmp++; if (rx_v[0] !== 17'd256) begin n_mis++; $display("FAIL rnd_rx: got %0d want 256", rx_v[0]); end
        n_cmp++; if (seq_v[0] !== 1'b0)   begin n_mis++; $display("FAIL rnd_seq_err: got %0d want 0", seq_v[0]); end
        n_cmp++; if (proto_v[0] !== 1'b0) begin n_mis++; $display("FAIL rnd_proto_err: got %0d want 0", proto_v[0]); end
        n_cmp++; if (rdy_v[0] !== 1'b0)   begin n_mis++; $display("FAIL rnd_ready_done: got %0d want 0", rdy_v[0]); end
    endtask

    task automatic test_sequence_gap();
        do_reset(2);
        beat_q = '{0, 1, 2, 4, 5, 7};
        feed(1, 100, 0);
        n_cmp++; if (err_v[1] !== 8'd2)  begin n_mis++; $display("FAIL gap_err_cnt: got %0d want 2", err_v[1]); end
        n_cmp++; if (seq_v[1] !== 1'b1)  begin n_mis++; $display("FAIL gap_seq_err: got %0d want 1", seq_v[1]); end
        n_cmp++; if (exp_b !== 9'd8)     begin n_mis++; $display("FAIL gap_expect: got %0d want 8", exp_b); end
        n_cmp++; if (done_v[1] !== 1'b1) begin n_mis++; $display("FAIL gap_done: got %0d want 1", done_v[1]); end
        n_cmp++; if (rx_v[1] !== 17'd6)  begin n_mis++; $display("FAIL gap_rx: got %0d want 6", rx_v[1]); end
        n_cmp++; if (proto_v[1] !== 1'b0) begin n_mis++; $display("FAIL gap_proto: got %0d want 0", proto_v[1]); end
    endtask

    task automatic test_wrap();
        do_reset(2);
        beat_q = '{14, 15, 0, 1};
        feed(2, 100, 0);
        n_cmp++; if (err_v[2] !== 8'd0)  begin n_mis++; $display("FAIL wrap_err_cnt: got %0d want 0", err_v[2]); end
        n_cmp++; if (seq_v[2] !== 1'b0)  begin n_mis++; $display("FAIL wrap_seq_err: got %0d want 0", seq_v[2]); end
        n_cmp++; if (done_v[2] !== 1'b1) begin n_mis++; $display("FAIL wrap_done: got %0d want 1", done_v[2]); end
        n_cmp++; if (exp_c !== 4'd2)     begin n_mis++; $display("FAIL wrap_expect: got %0d want 2", exp_c); end
        n_cmp++; if (rx_v[2] !== 17'd4)  begin n_mis++; $display("FAIL wrap_rx: got %0d want 4", rx_v[2]); end
    endtask

    // Constant data 5: every one of the 256 beats mismatches, count must stop at 255.
    task automatic test_err_saturation();
        do_reset(2);
        beat_q.delete();
        for (int i = 0; i < 256; i++) beat_q.push_back(5);
        feed(0, 400, 0);
        n_cmp++; if (err_v[0] !== 8'd255) begin n_mis++; $display("FAIL sat_err_cnt: got %0d want 255", err_v[0]); end
        n_cmp++; if (seq_v[0] !== 1'b1)   begin n_mis++; $display("FAIL sat_seq_err: got %0d want 1", seq_v[0]); end
        n_cmp++; if (exp_a !== 9'd6)      begin n_mis++; $display("FAIL sat_expect: got %0d want 6", exp_a); end
        n_cmp++; if (done_v[0] !== 1'b1)  begin n_mis++; $display("FAIL sat_done: got %0d want 1", done_v[0]); end
    endtask

    task automatic test_stall_rules();
        // Run 1: valid dropped during a stall.
        do_reset(2);
        vaild_v[0] = 1'b1;
        data_v[0]  = 9'd3;
        cycle();
        cycle();
        n_cmp++; if (proto_v[0] !== 1'b0) begin n_mis++; $display("FAIL stall_ok_proto: got %0d want 0", proto_v[0]); end
        n_cmp++; if (rx_v[0] !== 17'd0)   begin n_mis++; $display("FAIL stall_rx: got %0d want 0", rx_v[0]); end
        n_cmp++; if (exp_a !== 9'd0)      begin n_mis++; $display("FAIL stall_expect: got %0d want 0", exp_a); end
        vaild_v[0] = 1'b0;
        cycle();
        n_cmp++; if (proto_v[0] !== 1'b1) begin n_mis++; $display("FAIL stall_drop_proto: got %0d want 1", proto_v[0]); end
        // Run 2: data changed 3 -> 9 during a stall.
        do_reset(1);
        vaild_v[0] = 1'b1;
        data_v[0]  = 9'd3;
        cycle();
        cycle();
        cycle();
        n_cmp++; if (proto_v[0] !== 1'b0) begin n_mis++; $display("FAIL stall_hold_proto: got %0d want 0", proto_v[0]); end
        data_v[0] = 9'd9;
        cycle();
        n_cmp++; if (proto_v[0] !== 1'b1) begin n_mis++; $display("FAIL stall_data_proto: got %0d want 1", proto_v[0]); end
        n_cmp++; if ({err_v[0], seq_v[0]} !== 9'd0)
            begin n_mis++; $display("FAIL stall_no_seq: got %0d/%0d want 0/0", err_v[0], seq_v[0]); end
        vaild_v[0] = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset(2);
        beat_q.delete();
        for (int i = 0; i <= 100; i++) if (i != 50) beat_q.push_back(i);
        feed(0, 300, 0);
        n_cmp++; if (rx_v[0] !== 17'd100) begin n_mis++; $display("FAIL mid_rx_100: got %0d want 100", rx_v[0]); end
        n_cmp++; if (err_v[0] !== 8'd1)   begin n_mis++; $display("FAIL mid_err_1: got %0d want 1", err_v[0]); end
        s_rst = 1'b1;
        cycle();
        s_rst = 1'b0;
        n_cmp++; if (rx_v[0] !== 17'd0)   begin n_mis++; $display("FAIL mid_rx_clr: got %0d want 0", rx_v[0]); end
        n_cmp++; if (err_v[0] !== 8'd0)   begin n_mis++; $display("FAIL mid_err_clr: got %0d want 0", err_v[0]); end
        n_cmp++; if ({seq_v[0], proto_v[0], done_v[0]} !== 3'b000)
            begin n_mis++; $display("FAIL mid_flags_clr: got %b want 000", {seq_v[0], proto_v[0], done_v[0]}); end
        n_cmp++; if (exp_a !== 9'd0)      begin n_mis++; $display("FAIL mid_expect_clr: got %0d want 0", exp_a); end
        n_cmp++; if (rdy_v[0] !== 1'b0)   begin n_mis++; $display("FAIL mid_ready_clr: got %0d want 0", rdy_v[0]); end
        beat_q.delete();
        for (int i = 0; i < 256; i++) beat_q.push_back(i);
        feed(0, 400, 0);
        n_cmp++; if (done_v[0] !== 1'b1)  begin n_mis++; $display("FAIL rerun_done: got %0d want 1", done_v[0]); end
        n_cmp++; if (rx_v[0] !== 17'd256) begin n_mis++; $display("FAIL rerun_rx: got %0d want 256", rx_v[0]); end
        n_cmp++; if (err_v[0] !== 8'd0)   begin n_mis++; $display("FAIL rerun_err: got %0d want 0", err_v[0]); end
        n_cmp++; if ({seq_v[0], proto_v[0]} !== 2'b00)
            begin n_mis++; $display("FAIL rerun_flags: got %b want 00", {seq_v[0], proto_v[0]}); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_random_backpressure();
        test_sequence_gap();
        test_wrap();
        test_err_saturation();
        test_stall_rules();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
